// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator. Horizontal/vertical counters advance
//   on clk cycles with ce=1. All decoded outputs are computed from the next
//   counter values and registered alongside the counters, so they describe
//   the pixel currently addressed by hcount/vcount.
//
// Ports
//   clk        system/pixel clock
//   rst        synchronous active-high reset
//   ce         pixel enable (raster advances only when high)
//   hcount     current pixel column
//   vcount     current line
//   hblnk      horizontal blanking (hcount >= H_ACTIVE)
//   vblnk      vertical blanking (vcount >= V_ACTIVE)
//   hsync      horizontal sync at HSYNC_POL level inside the sync interval
//   vsync      vertical sync at VSYNC_POL level inside the sync interval
//   de         display enable (~hblnk & ~vblnk)
//   sof        one-clk pulse when the raster wraps to (0,0)
//   eol        one-clk pulse when hcount wraps to 0
//   frame_cnt  completed frame count, wraps modulo 2^FW
module vga_timing_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CW        = 11,
  parameter int FW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hblnk,
  output logic          vblnk,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          sof,
  output logic          eol,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_interval
      $fatal(1, "vga_timing_gen: every timing interval must be >= 1");
    end
    if (CW < 1 || CW > 30 || (64'd1 << CW) < 64'(MAX_TOTAL)) begin : g_bad_cw
      $fatal(1, "vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
  endgenerate

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          hblnk_next;
  logic          vblnk_next;
  logic          hsync_act;
  logic          vsync_act;

  always_comb begin
    h_wrap     = (hcount == H_LAST);
    v_wrap     = (vcount == V_LAST);
    h_next     = h_wrap ? '0 : hcount + CW'(1);
    v_next     = vcount;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vcount + CW'(1);
    end
    hblnk_next = (h_next >= H_ACT);
    vblnk_next = (v_next >= V_ACT);
    hsync_act  = (h_next >= HS_START) && (h_next < HS_END);
    vsync_act  = (v_next >= VS_START) && (v_next < VS_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount    <= '0;
      vcount    <= '0;
      frame_cnt <= '0;
      hblnk     <= 1'b0;
      vblnk     <= 1'b0;
      de        <= 1'b1;
      hsync     <= ~HSYNC_POL;
      vsync     <= ~VSYNC_POL;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else begin
      // Pulses default low so they last exactly one clk, even when ce stays low.
      sof <= 1'b0;
      eol <= 1'b0;
      if (ce) begin
        hcount <= h_next;
        vcount <= v_next;
        hblnk  <= hblnk_next;
        vblnk  <= vblnk_next;
        de     <= ~hblnk_next & ~vblnk_next;
        hsync  <= hsync_act ? HSYNC_POL : ~HSYNC_POL;
        vsync  <= vsync_act ? VSYNC_POL : ~VSYNC_POL;
        eol    <= h_wrap;
        sof    <= h_wrap & v_wrap;
        if (h_wrap && v_wrap) begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst, ce, rst2, ce2;
  logic [3:0] hcount, vcount, hcount2, vcount2;
  logic       hblnk, vblnk, hsync, vsync, de, sof, eol;
  logic       hblnk2, vblnk2, hsync2, vsync2, de2, sof2, eol2;
  logic [3:0] frame_cnt;
  logic [1:0] frame_cnt2;

  int errors = 0;
  int checks = 0;

  // expected raster position for dut (eh/ev/ef) and dut2 (gh/gv/gf)
  int eh, ev, ef, gh, gv, gf;
  bit esof, eeol;
  int sof_pulses;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4), .FW(4)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .hcount(hcount), .vcount(vcount), .hblnk(hblnk), .vblnk(vblnk),
    .hsync(hsync), .vsync(vsync), .de(de), .sof(sof), .eol(eol),
    .frame_cnt(frame_cnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(4), .FW(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .ce(ce2),
    .hcount(hcount2), .vcount(vcount2), .hblnk(hblnk2), .vblnk(vblnk2),
    .hsync(hsync2), .vsync(vsync2), .de(de2), .sof(sof2), .eol(eol2),
    .frame_cnt(frame_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance dut's expected position for one clk with the given ce.
  task automatic model_step(input bit en);
    esof = 1'b0;
    eeol = 1'b0;
    if (en) begin
      if (eh == 14) begin
        eh   = 0;
        eeol = 1'b1;
        if (ev == 7) begin
          ev   = 0;
          esof = 1'b1;
          ef   = (ef + 1) % 16;
        end else begin
          ev = ev + 1;
        end
      end else begin
        eh = eh + 1;
      end
    end
  endtask

  task automatic check_dut(input string ph);
    chk({ph, ".hcount"}, 32'(hcount), 32'(eh));
    chk({ph, ".vcount"}, 32'(vcount), 32'(ev));
    chk({ph, ".hblnk"}, 32'(hblnk), 32'(eh >= 8));
    chk({ph, ".vblnk"}, 32'(vblnk), 32'(ev >= 4));
    chk({ph, ".hsync"}, 32'(hsync), 32'(eh >= 10 && eh <= 12));
    chk({ph, ".vsync"}, 32'(vsync), 32'(ev >= 5 && ev <= 6));
    chk({ph, ".de"}, 32'(de), 32'(eh < 8 && ev < 4));
    chk({ph, ".sof"}, 32'(sof), 32'(esof));
    chk({ph, ".eol"}, 32'(eol), 32'(eeol));
    chk({ph, ".frame"}, 32'(frame_cnt), 32'(ef));
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; rst2 = 1'b1; ce2 = 1'b1;
    eh = 0; ev = 0; ef = 0; esof = 0; eeol = 0;

    // reset held 3 clk
    for (int i = 0; i < 3; i++) begin
      tick();
      check_dut("reset");
      chk("reset.hsync2", 32'(hsync2), 32'd1);
      chk("reset.vsync2", 32'(vsync2), 32'd1);
    end

    // release with ce=1: one full frame of 120 clk
    rst = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      tick();
      model_step(1'b1);
      check_dut("run");
      if (i == 14) chk("run.h14", 32'(hcount), 32'd14);
      if (i == 15) begin
        chk("run.line1_v", 32'(vcount), 32'd1);
        chk("run.line1_eol", 32'(eol), 32'd1);
      end
    end
    chk("frame1.sof", 32'(sof), 32'd1);
    chk("frame1.eol", 32'(eol), 32'd1);
    chk("frame1.cnt", 32'(frame_cnt), 32'd1);

    // ce pattern 1,0,0: one frame takes 360 clk
    sof_pulses = 0;
    for (int k = 0; k < 360; k++) begin
      ce = (k % 3 == 0);
      tick();
      model_step(ce);
      check_dut("ce");
      if (sof) sof_pulses++;
    end
    chk("ce.frame", 32'(frame_cnt), 32'd2);
    chk("ce.sof_pulses", 32'(sof_pulses), 32'd1);
    chk("ce.pos_h", 32'(hcount), 32'd0);
    chk("ce.pos_v", 32'(vcount), 32'd0);

    // extra held cycle: sof must drop, position hold
    ce = 1'b0;
    tick();
    model_step(1'b0);
    check_dut("hold");

    // run to (6,3), then reset mid-frame
    ce = 1'b1;
    for (int i = 0; i < 51; i++) begin
      tick();
      model_step(1'b1);
      check_dut("pre_rst");
    end
    chk("pre_rst.h", 32'(hcount), 32'd6);
    chk("pre_rst.v", 32'(vcount), 32'd3);
    rst = 1'b1;
    tick();
    eh = 0; ev = 0; ef = 0; esof = 0; eeol = 0;
    check_dut("midrst");
    // reset wins over ce=0 as well
    ce = 1'b0;
    tick();
    check_dut("midrst_ce0");
    rst = 1'b0; ce = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      model_step(1'b1);
      check_dut("post_rst");
    end

    // active-low sync polarity and 2-bit frame counter wrap
    gh = 0; gv = 0; gf = 0;
    rst2 = 1'b0; ce2 = 1'b1;
    for (int i = 1; i <= 480; i++) begin
      tick();
      if (gh == 14) begin
        gh = 0;
        if (gv == 7) begin gv = 0; gf = (gf + 1) % 4; end
        else gv = gv + 1;
      end else begin
        gh = gh + 1;
      end
      chk("pol.hcount", 32'(hcount2), 32'(gh));
      chk("pol.vcount", 32'(vcount2), 32'(gv));
      chk("pol.hsync", 32'(hsync2), 32'(!(gh >= 10 && gh <= 12)));
      chk("pol.vsync", 32'(vsync2), 32'(!(gv >= 5 && gv <= 6)));
      chk("pol.frame", 32'(frame_cnt2), 32'(gf));
      if (i == 360) chk("pol.frame3", 32'(frame_cnt2), 32'd3);
    end
    chk("pol.wrap0", 32'(frame_cnt2), 32'd0);
    chk("pol.sof", 32'(sof2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator, the successor to the fixed-mode VGA timing controller. Every horizontal and vertical interval, the sync polarity and the counter width are parameters. A pixel clock-enable lets the block run from a faster system clock. All outputs are registered and refer to the pixel currently addressed by `hcount`/`vcount`. The block sits at the head of the video pipeline and feeds background/sprite/overlay stages and the VGA output register.

## Interface
Parameters:
- `H_ACTIVE`, default 800: visible pixels per line.
- `H_FP`, default 40: horizontal front porch, in pixels.
- `H_SYNC`, default 128: horizontal sync width, in pixels.
- `H_BP`, default 88: horizontal back porch, in pixels.
- `V_ACTIVE`, default 600: visible lines per frame.
- `V_FP`, default 1: vertical front porch, in lines.
- `V_SYNC`, default 4: vertical sync width, in lines.
- `V_BP`, default 23: vertical back porch, in lines.
- `HSYNC_POL`, default 1: active level of `hsync` (1 = active-high).
- `VSYNC_POL`, default 1: active level of `vsync`.
- `CW`, default 11: width of `hcount`/`vcount`. Must hold H_TOTAL-1 and V_TOTAL-1.
- `FW`, default 8: width of the frame counter.

Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system/pixel clock.
- `rst`  in  1  synchronous active-high reset.
- `ce`  in  1  pixel enable; the raster advances only on cycles with ce=1. Tie high for pixel-rate clk.
- `hcount`  out  CW  current pixel column.
- `vcount`  out  CW  current line.
- `hblnk`  out  1  high when hcount >= H_ACTIVE.
- `vblnk`  out  1  high when vcount >= V_ACTIVE.
- `hsync`  out  1  at HSYNC_POL level when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; otherwise at the inverse level.
- `vsync`  out  1  at VSYNC_POL level when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC; otherwise at the inverse level.
- `de`  out  1  ~hblnk & ~vblnk.
- `sof`  out  1  start-of-frame pulse.
- `eol`  out  1  end-of-line pulse.
- `frame_cnt`  out  FW  count of completed frames; wraps modulo 2^FW.

## Operation
- Counting, on each clk with ce=1:
  - hcount increments.
  - At hcount = H_TOTAL-1, hcount goes to 0 and vcount increments.
  - At vcount = V_TOTAL-1 on that same wrap, vcount goes to 0 and frame_cnt increments, wrapping at 2^FW.
- ce=0: counters, `hblnk`, `vblnk`, `hsync`, `vsync` and `de` hold their values.
- Decoded outputs are computed from the next counter values and registered together with the counters. Every output is therefore cycle-aligned with `hcount`/`vcount`, with no off-by-one.
- `sof` is high for exactly one clk: the clk after the ce cycle on which the counters wrapped to (0,0). It is 0 on every other cycle, including held ce=0 cycles.
- `eol` is high for exactly one clk: the clk after the ce cycle on which hcount wrapped to 0.
- Reset values:
  - hcount = 0, vcount = 0, frame_cnt = 0.
  - hblnk = 0, vblnk = 0, de = 1.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - sof = 0, eol = 0.
- Reset mid-frame: on the next clk every output takes its reset value, whatever the value of ce. Counting resumes from (0,0) on the first ce cycle after rst drops, and no `sof` is issued for the reset itself.
- rst has priority over ce.
- Elaboration: fatal assertion if any interval parameter < 1, or if 2^CW < max(H_TOTAL, V_TOTAL).

## Timing
- Latency: 0 cycles between counter value and decoded outputs; they are the same register stage.
- With ce held at 1:
  - Line period = H_TOTAL clk.
  - Frame period = H_TOTAL*V_TOTAL clk.
- With ce duty 1/N, periods scale by N. Outputs change only in the clk after a ce=1 cycle.
- Sync edges:
  - hsync asserts on the cycle hcount = H_ACTIVE+H_FP.
  - hsync deasserts on the cycle hcount = H_ACTIVE+H_FP+H_SYNC.
  - vsync asserts and deasserts on the corresponding vcount values, and switches on the same clk as vcount changes (hcount = 0).
- Simultaneous line and frame wrap: `eol` and `sof` are both high on the same clk.

## Test plan
Unless stated otherwise, scenarios use the small mode: H = 8/2/3/2 (H_TOTAL 15), V = 4/1/2/1 (V_TOTAL 8), CW=4, FW=4.
- Reset check: assert rst for 3 clk, release with ce=1 -> after release hcount=0, vcount=0, de=1, hsync=0, vsync=0, sof=0; hcount reaches 14 after 14 clk, then 0 with vcount=1 and eol=1.
- Horizontal decode: run one line with ce=1 -> hblnk high for hcount 8..14; hsync high only for hcount 10..12; de high for hcount 0..7 on line 0.
- Vertical decode and frame: run 120 clk with ce=1 -> vblnk high for vcount 4..7; vsync high for vcount 5..6; sof=1 and eol=1 exactly at clk 120; frame_cnt=1.
- Clock enable: ce pattern 1,0,0 repeated -> every output holds for two clk between advances; frame completes after 360 clk; sof is a single 1-clk pulse.
- Polarity and wrap: HSYNC_POL=0, VSYNC_POL=0, FW=2 -> hsync low for hcount 10..12, otherwise high; after 4 frames frame_cnt wraps 3 -> 0.
- Mid-frame reset: assert rst at hcount=6, vcount=3 with ce=1 -> next clk all outputs at reset values, no sof, frame_cnt=0.
